// File: rtl/cont_servo_pkg.sv
// cont_servo_pkg: shared constants and RX state encoding for the servo test controller.
package cont_servo_pkg;
  localparam int BAUD_DIV   = 87;
  localparam int PWM_PERIOD = 200000;
  localparam int PULSE_MID  = 15000;
  localparam int PULSE_STEP = 39;
  localparam int PW         = 18;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
endpackage

// File: rtl/cont_servo_uart_rx.sv
// cont_servo_uart_rx: 8N1 UART receiver with 2-flop synchroniser; framing errors park in BREAK until the line idles high.
module cont_servo_uart_rx #(
  parameter int BAUD_DIV = cont_servo_pkg::BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rxd,
  output logic [7:0] o_data,
  output logic       o_valid
);
  import cont_servo_pkg::*;
  localparam int CW = $clog2(BAUD_DIV + 1);
  rx_state_t     r_state;
  logic [2:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic          w_rx, w_fall, w_half, w_full;
  // r_sync[1] is the synchronised line, r_sync[2] its previous value for edge detection
  assign w_rx   = r_sync[1];
  assign w_fall = r_sync[2] & ~r_sync[1];
  assign w_half = r_cnt == CW'(BAUD_DIV / 2);
  assign w_full = r_cnt == CW'(BAUD_DIV - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 3'b111;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      r_sync  <= {r_sync[1:0], i_rxd};
      o_valid <= 1'b0;
      r_cnt   <= r_cnt + 1'b1;
      case (r_state)
        RX_IDLE: begin
          r_cnt <= '0;
          if (w_fall) r_state <= RX_START;
        end
        RX_START: if (w_half) begin
          r_cnt   <= '0;
          r_bit   <= '0;
          r_state <= w_rx ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (w_full) begin
          r_cnt  <= '0;
          o_data <= {w_rx, o_data[7:1]};
          r_bit  <= r_bit + 3'd1;
          if (r_bit == 3'd7) r_state <= RX_STOP;
        end
        RX_STOP: if (w_full) begin
          r_cnt   <= '0;
          o_valid <= w_rx;
          r_state <= w_rx ? RX_IDLE : RX_BREAK;
        end
        RX_BREAK: if (w_rx) r_state <= RX_IDLE;
        default: r_state <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/cont_servo_test_mss.sv
// cont_servo_test_mss: UART speed bytes drive a 50 Hz continuous-servo PWM.
// Define CONT_SERVO_ECHO_EN to retransmit each accepted byte on UART_0_TXD.
module cont_servo_test_mss #(
  parameter int BAUD_DIV   = cont_servo_pkg::BAUD_DIV,
  parameter int PWM_PERIOD = cont_servo_pkg::PWM_PERIOD,
  parameter int PULSE_MID  = cont_servo_pkg::PULSE_MID,
  parameter int PULSE_STEP = cont_servo_pkg::PULSE_STEP
) (
  input  logic SYSCLK,
  input  logic MSS_RESET_N,
  input  logic UART_0_RXD,
  output logic UART_0_TXD,
  output logic GPIO_0_OUT,
  inout  wire  I2C_1_SDA,
  inout  wire  I2C_1_SCL
);
  import cont_servo_pkg::*;
  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic signed [PW-1:0] MID_S  = PW'(PULSE_MID);
  localparam logic signed [PW-1:0] STEP_S = PW'(PULSE_STEP);
  logic [7:0]             w_rx_data;
  logic                   w_rx_valid;
  logic [7:0]             r_speed;
  logic signed [PW-1:0]   w_spd, w_pulse, r_active;
  logic [PW-1:0]          r_cnt;
  logic                   r_gpio;
  logic                   w_wrap;
  assign I2C_1_SDA = 1'bz;
  assign I2C_1_SCL = 1'bz;
  cont_servo_uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk    (SYSCLK),
    .rst_n  (MSS_RESET_N),
    .i_rxd  (UART_0_RXD),
    .o_data (w_rx_data),
    .o_valid(w_rx_valid)
  );
  assign w_spd   = {{(PW-8){r_speed[7]}}, r_speed};
  assign w_pulse = MID_S + w_spd * STEP_S;
  assign w_wrap  = r_cnt == PW'(PWM_PERIOD - 1);
  // the pulse width is only swapped at the frame boundary so a frame is never cut short or stretched
  always_ff @(posedge SYSCLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      r_speed  <= '0;
      r_cnt    <= '0;
      r_active <= MID_S;
      r_gpio   <= 1'b0;
    end else begin
      if (w_rx_valid) r_speed <= w_rx_data;
      r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap) r_active <= w_pulse;
      r_gpio <= r_cnt < $unsigned(r_active);
    end
  end
  assign GPIO_0_OUT = r_gpio;
`ifdef CONT_SERVO_ECHO_EN
  logic          r_txd, r_busy;
  logic [8:0]    r_tx_sh;
  logic [3:0]    r_tx_bit;
  logic [CW-1:0] r_tx_cnt;
  // a byte arriving while busy is not queued: its echo is simply lost
  always_ff @(posedge SYSCLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      r_txd    <= 1'b1;
      r_busy   <= 1'b0;
      r_tx_sh  <= '1;
      r_tx_bit <= '0;
      r_tx_cnt <= '0;
    end else if (!r_busy) begin
      if (w_rx_valid) begin
        r_busy   <= 1'b1;
        r_txd    <= 1'b0;
        r_tx_sh  <= {1'b1, w_rx_data};
        r_tx_bit <= '0;
        r_tx_cnt <= '0;
      end
    end else if (r_tx_cnt != CW'(BAUD_DIV - 1)) begin
      r_tx_cnt <= r_tx_cnt + 1'b1;
    end else begin
      r_tx_cnt <= '0;
      r_tx_bit <= r_tx_bit + 4'd1;
      if (r_tx_bit == 4'd9) r_busy <= 1'b0;
      else begin
        r_txd   <= r_tx_sh[0];
        r_tx_sh <= {1'b1, r_tx_sh[8:1]};
      end
    end
  end
  assign UART_0_TXD = r_txd;
`else
  assign UART_0_TXD = 1'b1;
`endif
endmodule

// File: tb/tb_cont_servo_test_mss.sv
// tb_cont_servo_test_mss: scoreboard bench; expected pulse widths are queued per frame and checked as pulses end.
module tb_cont_servo_test_mss;
  localparam int B = 8;
  localparam int P = 2000;
  localparam int M = 1000;
  localparam int S = 7;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxd = 1'b0;
  wire  txd, gpio, sda, scl;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   exp_q[$];
  int   s_model = 0;
  bit   txd_low = 0;
`ifdef CONT_SERVO_ECHO_EN
  logic [7:0] echo_q[$];
  int   last_echo = 0;
  bit   have_echo = 0;
`endif

  cont_servo_test_mss #(.BAUD_DIV(B), .PWM_PERIOD(P), .PULSE_MID(M), .PULSE_STEP(S)) dut (
    .SYSCLK     (clk),
    .MSS_RESET_N(rst_n),
    .UART_0_RXD (rxd),
    .UART_0_TXD (txd),
    .GPIO_0_OUT (gpio),
    .I2C_1_SDA  (sda),
    .I2C_1_SCL  (scl)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pulse_of(input logic [7:0] b);
    int s;
    s = byte'(b);
    return M + s * S;
  endfunction

  task automatic wait_rise();
    bit ok = 0;
    logic last = gpio;
    for (int i = 0; i < 3 * P && !ok; i++) begin
      @(negedge clk);
      ok = gpio && !last;
      last = gpio;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL frame_start: got no rising edge expected one within %0d cycles", 3 * P);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
`ifdef CONT_SERVO_ECHO_EN
    if (stop_ok && (!have_echo || cyc - last_echo > 10 * B)) begin
      echo_q.push_back(b);
      last_echo = cyc;
      have_echo = 1;
    end
`endif
    if (stop_ok) s_model = byte'(b);
    rxd = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (B) @(negedge clk);
    end
    rxd = stop_ok;
    repeat (B) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic push_next();
    exp_q.push_back(M + s_model * S);
  endtask

  // pulse-width and frame-period monitor
  initial begin
    int  run = 0;
    int  since = 0;
    bit  prev = 0;
    bit  have_rise = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 0;
        since = 0;
        prev = 0;
        have_rise = 0;
      end else begin
        since++;
        if (gpio && !prev) begin
          if (have_rise) chk("period", since, P);
          have_rise = 1;
          since = 0;
        end
        if (gpio) run++;
        if (!gpio && prev) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pulse: got %0d expected no pulse queued", run);
          end else chk("pulse", run, exp_q.pop_front());
          run = 0;
        end
        prev = gpio;
      end
    end
  end

`ifdef CONT_SERVO_ECHO_EN
  initial begin
    logic [7:0] v;
    forever begin
      @(negedge clk);
      if (rst_n && !txd) begin
        repeat (B / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          v[i] = txd;
        end
        repeat (B) @(negedge clk);
        chk("echo_stop", txd, 1);
        if (echo_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL echo: got %0h expected no echo", v);
        end else chk("echo_byte", v, echo_q.pop_front());
      end
    end
  end
`else
  initial forever begin
    @(negedge clk);
    if (txd !== 1'b1) txd_low = 1;
  end
`endif

  initial begin
    logic [7:0] b;
    bit err;
    int n, gap;
    exp_q.push_back(M);
    rxd = 1'b0;
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    wait_rise();
    push_next();
    wait_rise();
    rxd = 1'b1;
    push_next();
    wait_rise();
    send_byte(8'h7F, 1);
    chk("model_max", pulse_of(8'h7F), M + 127 * S);
    push_next();
    wait_rise();
    send_byte(8'h80, 1);
    push_next();
    wait_rise();
    send_byte(8'h00, 1);
    push_next();
    wait_rise();
    send_byte(8'hA5, 0);
    repeat (2 * B) @(negedge clk);
    send_byte(8'h10, 1);
    push_next();
    wait_rise();
    send_byte(8'h05, 1);
    send_byte(8'hFB, 1);
    push_next();
    wait_rise();
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * B) @(negedge clk);
    push_next();
    wait_rise();
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("gpio_async_reset", gpio, 0);
    chk("txd_reset", txd, 1);
    exp_q.delete();
    s_model = 0;
`ifdef CONT_SERVO_ECHO_EN
    echo_q.delete();
    have_echo = 0;
`endif
    exp_q.push_back(M);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    for (int f = 0; f < 15; f++) begin
      wait_rise();
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) begin
        err = $urandom_range(0, 5) == 0;
        b = 8'($urandom);
        send_byte(b, !err);
        gap = err ? $urandom_range(1, 3) : $urandom_range(0, 3);
        repeat (gap * B) @(negedge clk);
      end
      push_next();
    end
    for (int i = 0; i < 3 * P && exp_q.size() != 0; i++) @(negedge clk);
    chk("pulses_left", exp_q.size(), 0);
`ifdef CONT_SERVO_ECHO_EN
    for (int i = 0; i < 20 * B && echo_q.size() != 0; i++) @(negedge clk);
    chk("echoes_left", echo_q.size(), 0);
`else
    chk("txd_idle", txd_low, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
